ext_pipe_unit: RTL and testbench

//  Parametrised immediate-extension stage for the BIP datapath. It is the successor
//  to the combinational 11->16 sign extender.
//  - Accepts IN_W-bit operands with a per-transfer mode: zero-ext, sign-ext,

---
 rtl/ext_pipe_unit.sv | 78 +++++++
 tb/tb_ext_pipe_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ext_pipe_unit.sv
// rtl/ext_pipe_unit.sv - immediate-extension stage with a result FIFO behind a valid/ready handshake
module ext_pipe_unit #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 16,
    parameter int DEPTH = 2,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  operand,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data,
    output logic [LVL_W-1:0] level
);

    localparam int EXT_W = OUT_W - IN_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_inc, rd_inc, rd_nxt;
    logic [LVL_W-1:0] level_nxt, level_after_pop;
    logic [OUT_W-1:0] sext, ext_val;
    logic             push, pop;

    always_comb begin
        sext = {{EXT_W{operand[IN_W-1]}}, operand};
        case (mode)
            2'b00:   ext_val = {{EXT_W{1'b0}}, operand};
            2'b01:   ext_val = sext;
            2'b10:   ext_val = {operand, {EXT_W{1'b0}}};
            default: ext_val = {sext[OUT_W-2:0], 1'b0};
        endcase
    end

    assign in_ready  = (level < LVL_W'(DEPTH)) & ~flush;
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_inc          = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        rd_inc          = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        rd_nxt          = pop ? rd_inc : rd_ptr;
        level_after_pop = pop ? level - 1'b1 : level;
        level_nxt       = push ? level_after_pop + 1'b1 : level_after_pop;
    end

    // data is a register tracking the head so it holds its value once the FIFO drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            data   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= ext_val;
                wr_ptr      <= wr_inc;
            end
            rd_ptr <= rd_nxt;
            level  <= level_nxt;
            // a push into an otherwise-empty queue becomes the head directly
            if (level_nxt != '0)
                data <= (push && level_after_pop == '0) ? ext_val : mem[rd_nxt];
        end
    end

endmodule

// File: tb/tb_ext_pipe_unit.sv
// tb/tb_ext_pipe_unit.sv - self-checking bench for ext_pipe_unit
module tb_ext_pipe_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [10:0] operand;
    logic [1:0]  mode;
    logic [15:0] data;
    logic [1:0]  level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_pipe_unit #(.IN_W(11), .OUT_W(16), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand(operand), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .data(data), .level(level)
    );

    typedef struct {
        logic        iv;
        logic [10:0] op;
        logic [1:0]  md;
        logic        ordy;
        logic        fl;
        logic        e_valid;
        logic [15:0] e_data;
        logic [1:0]  e_level;
        logic        e_irdy;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic iv, logic [10:0] op, logic [1:0] md, logic ordy, logic fl,
                                logic ev, logic [15:0] ed, logic [1:0] el, logic er);
        vec_t v;
        v.iv = iv; v.op = op; v.md = md; v.ordy = ordy; v.fl = fl;
        v.e_valid = ev; v.e_data = ed; v.e_level = el; v.e_irdy = er;
        return v;
    endfunction

    function automatic logic [15:0] ext_model(logic [10:0] op, logic [1:0] md);
        case (md)
            2'd0:    return {5'b0, op};
            2'd1:    return {{5{op[10]}}, op};
            2'd2:    return {op, 5'b0};
            default: return {{4{op[10]}}, op, 1'b0};
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [15:0] sb[$];
    logic [15:0] expv;
    int pushes, pops;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operand = '0; mode = '0;

        vecs[0]  = mk(1, 11'h555, 2'd0, 1, 0, 1, 16'h0555, 2'd1, 1);
        vecs[1]  = mk(1, 11'h555, 2'd1, 1, 0, 1, 16'hFD55, 2'd1, 1);
        vecs[2]  = mk(1, 11'h555, 2'd2, 1, 0, 1, 16'hAAA0, 2'd1, 1);
        vecs[3]  = mk(1, 11'h555, 2'd3, 1, 0, 1, 16'hFAAA, 2'd1, 1);
        vecs[4]  = mk(0, 11'h000, 2'd2, 1, 0, 0, 16'h0000, 2'd0, 1);
        vecs[5]  = mk(1, 11'h001, 2'd1, 0, 0, 1, 16'h0001, 2'd1, 1);
        vecs[6]  = mk(1, 11'h7FF, 2'd1, 0, 0, 1, 16'h0001, 2'd2, 0);
        vecs[7]  = mk(1, 11'h123, 2'd0, 0, 0, 1, 16'h0001, 2'd2, 0);
        vecs[8]  = mk(0, 11'h000, 2'd3, 1, 0, 1, 16'hFFFF, 2'd1, 1);
        vecs[9]  = mk(0, 11'h000, 2'd0, 1, 0, 0, 16'h0000, 2'd0, 1);
        vecs[10] = mk(1, 11'h002, 2'd0, 0, 0, 1, 16'h0002, 2'd1, 1);
        vecs[11] = mk(1, 11'h400, 2'd1, 1, 0, 1, 16'hFC00, 2'd1, 1);
        vecs[12] = mk(1, 11'h003, 2'd0, 0, 0, 1, 16'hFC00, 2'd2, 0);
        vecs[13] = mk(1, 11'h7AB, 2'd0, 1, 1, 0, 16'h0000, 2'd0, 0);
        vecs[14] = mk(0, 11'h7AB, 2'd1, 0, 0, 0, 16'h0000, 2'd0, 1);
        vecs[15] = mk(1, 11'h001, 2'd0, 0, 0, 1, 16'h0001, 2'd1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            in_valid = vecs[i].iv; operand = vecs[i].op; mode = vecs[i].md;
            out_ready = vecs[i].ordy; flush = vecs[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_level));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_irdy));
            if (vecs[i].e_valid)
                chk($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].e_data));
        end

        // asynchronous reset with two results queued
        in_valid = 1'b1; operand = 11'h0AA; mode = 2'd0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_level", 32'(level), 32'd2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_level", 32'(level), 32'd0);
        chk("async_data", 32'(data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // streaming with a scoreboard across pointer wrap
        pushes = 0; pops = 0;
        for (int cyc = 0; cyc < 200 && (pushes < 20 || sb.size() > 0); cyc++) begin
            in_valid  = (pushes < 20);
            operand   = 11'($urandom);
            mode      = 2'($urandom_range(0, 3));
            out_ready = (cyc % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("stream_unexpected_pop", 32'(data), 32'hDEAD);
                else begin
                    expv = sb.pop_front();
                    chk($sformatf("stream_pop%0d", pops), 32'(data), 32'(expv));
                end
                pops++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(ext_model(operand, mode));
                pushes++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("stream_pushes", 32'(pushes), 32'd20);
        chk("stream_pops", 32'(pops), 32'd20);
        chk("stream_drained_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
